pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Single clock; reset synchronous, active-high: clk (rising edge) and rs.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rs  input  1  synchronous active-high reset.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 data_in  input  16  word to scan, shifted MSB-first; captured with start.
REQ-006 len  input  5  number of bits to scan; captured with start; 0 or >16 means 16.
REQ-007 det_y  input  1  output of the external 1111 detector (Moore; high one cycle after the 4th consecutive 1 is clocked in).
REQ-008 det_w  output  1  serial bit driven to the detector's w input.
REQ-009 det_rs  output  1  reset driven to the detector.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 hit_cnt  output  5  number of sampled detector hits in the last scan.
REQ-013 first_hit  output  5  bit index (0..15) whose clocking produced the first hit; 5'h1F if none.

Function
REQ-014 The FSM has states IDLE, CLR, SHIFT, DRAIN and DONE, encoded in 3 bits.
- IDLE: start=1 latches data_in into a 16-bit shift register and the clamped len into a length register, clears hit_cnt to 0 and first_hit to 5'h1F, then goes to CLR.
- CLR: one cycle; det_rs=1, det_w=0; then SHIFT with bit index 0.
- SHIFT: det_w = shift register bit 15; each cycle shift left by 1 and increment the bit index; after len SHIFT cycles, go to DRAIN.
- DRAIN: one cycle; det_w=0; then DONE.
- DONE: one cycle; done=1; then IDLE.
REQ-015 det_rs = rs OR (state==CLR). det_w is 0 outside SHIFT.
REQ-016 Hit sampling windows:
- In SHIFT cycle i≥1, det_y belongs to bit i-1.
- In DRAIN, det_y belongs to bit len-1.
- In SHIFT cycle 0, det_y is ignored.
- Outside SHIFT and DRAIN, det_y is ignored.
REQ-017 Each window with det_y=1 increments hit_cnt by 1. The count is level-based, so a continuing run of 1s counts every cycle. hit_cnt maximum is 13, so it never wraps.
REQ-018 On the first window with det_y=1 in a scan, first_hit is loaded with that bit index; later hits leave it unchanged.
REQ-019 Latency: with start sampled at edge E, done is high during the (len+3)th cycle after E. busy is high from E+1 through the DONE cycle inclusive.
REQ-020 start while busy=1 is ignored and not queued. start in the DONE cycle is also ignored. start in the IDLE cycle immediately after DONE is accepted.
REQ-021 hit_cnt and first_hit hold their final values from the DONE cycle until the next accepted start.
REQ-022 data_in and len changing while busy have no effect on the current scan.

Reset
REQ-023 While rs=1, at every edge:
- state becomes IDLE; shift register, length register and bit index are cleared;
- hit_cnt=0, first_hit=5'h1F, busy=0, done=0, det_w=0;
- det_rs=1 combinationally.
REQ-024 rs asserted mid-scan in any state aborts the scan with no done pulse. A start coincident with rs is ignored.

Verification
REQ-025 The bench pairs the controller with a behavioural 1111 Moore detector model and checks each result the cycle done=1.
REQ-026 Reset: rs=1 for 2 cycles, start=1 -> busy=0, done=0, det_rs=1, hit_cnt=0, first_hit=31; after rs drops, still IDLE.
REQ-027 data_in=16'hF000, len=16 -> det_w sequence 1111 followed by twelve 0s; done at cycle 19 after start; hit_cnt=1, first_hit=3.
REQ-028 data_in=16'hFFFF, len=0 (treated as 16) -> hit_cnt=13, first_hit=3. Then data_in=16'hF7BC, len=16 (runs at bits 0-3, 5-8, 10-13) -> hit_cnt=3, first_hit=3.
REQ-029 data_in=16'hFFFF, len=3 -> hit_cnt=0, first_hit=31, done at cycle 6 after start.
REQ-030 Start 16'hFFFF, len=16; pulse start again at cycle 5 (ignored); assert rs at cycle 8 -> no done, busy=0 next cycle, hit_cnt=0. A new start after reset completes normally: hit_cnt=13.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serialises a 16-bit word MSB-first into an external
// "1111" Moore detector and records how many detector hits occurred and the
// bit index that produced the first one.
//
// Ports:
//   clk        system clock, rising edge
//   rs         synchronous active-high reset
//   start      scan request, sampled only in IDLE
//   data_in    word to scan, captured with start
//   len        bits to scan, captured with start (0 or >16 means 16)
//   det_y      detector output (high one cycle after the 4th consecutive 1)
//   det_w      serial bit to the detector
//   det_rs     detector reset (combinational: rs or CLR state)
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   hit_cnt    detector hits sampled in the last scan
//   first_hit  bit index of the first hit, 5'h1F when none
module pattern_scan_ctrl (
  input  logic        clk,
  input  logic        rs,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [4:0]  len,
  input  logic        det_y,
  output logic        det_w,
  output logic        det_rs,
  output logic        busy,
  output logic        done,
  output logic [4:0]  hit_cnt,
  output logic [4:0]  first_hit
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] NO_HIT  = 5'h1F;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  len_reg;
  logic [CNT_W-1:0]  bit_idx;

  logic [CNT_W-1:0]  len_eff_c;
  logic              win_valid_c;
  logic [CNT_W-1:0]  win_bit_c;
  logic              last_shift_c;

  // Clamp the requested length: 0 or anything above the word width scans all bits.
  assign len_eff_c = ((len == '0) || (len > MAX_LEN)) ? MAX_LEN : len;

  // The detector is one cycle behind det_w, so det_y seen now belongs to the
  // previous bit; the DRAIN cycle collects the verdict for the final bit.
  assign win_valid_c = ((state == SHIFT) && (bit_idx != '0)) || (state == DRAIN);
  assign win_bit_c   = (state == DRAIN) ? CNT_W'(len_reg - 5'd1)
                                        : CNT_W'(bit_idx - 5'd1);

  assign last_shift_c = (bit_idx == CNT_W'(len_reg - 5'd1));

  // Detector reset follows the block reset immediately and pulses during CLR.
  assign det_rs = rs | (state == CLR);

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rs) begin
      state     <= IDLE;
      shift_reg <= '0;
      len_reg   <= '0;
      bit_idx   <= '0;
      hit_cnt   <= '0;
      first_hit <= NO_HIT;
      busy      <= 1'b0;
      done      <= 1'b0;
      det_w     <= 1'b0;
    end else begin
      done <= 1'b0;

      // Level-based hit counting; a long run of 1s scores every window.
      if (win_valid_c && det_y) begin
        hit_cnt <= CNT_W'(hit_cnt + 5'd1);
        if (first_hit == NO_HIT) begin
          first_hit <= win_bit_c;
        end
      end

      case (state)
        IDLE: begin
          det_w <= 1'b0;
          if (start) begin
            shift_reg <= data_in;
            len_reg   <= len_eff_c;
            bit_idx   <= '0;
            hit_cnt   <= '0;
            first_hit <= NO_HIT;
            busy      <= 1'b1;
            state     <= CLR;
          end
        end

        CLR: begin
          // Present the MSB so it is on det_w during SHIFT cycle 0.
          bit_idx <= '0;
          det_w   <= shift_reg[DATA_W-1];
          state   <= SHIFT;
        end

        SHIFT: begin
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          bit_idx   <= CNT_W'(bit_idx + 5'd1);
          if (last_shift_c) begin
            det_w <= 1'b0;
            state <= DRAIN;
          end else begin
            det_w <= shift_reg[DATA_W-2];
          end
        end

        DRAIN: begin
          det_w <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          det_w <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: pairs pattern_scan_ctrl with a behavioural "1111"
// Moore detector. Stimulus pushes hand-computed expectations into a queue;
// an independent monitor pops and compares them whenever done is high.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        rs;
  logic        start;
  logic [15:0] data_in;
  logic [4:0]  len;
  logic        det_y;
  logic        det_w;
  logic        det_rs;
  logic        busy;
  logic        done;
  logic [4:0]  hit_cnt;
  logic [4:0]  first_hit;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          len_eff;
    int          hits;
    int          first;
    int          lat;
    logic [15:0] word;
    int          c;
  } exp_t;

  exp_t q[$];

  pattern_scan_ctrl dut (
    .clk       (clk),
    .rs        (rs),
    .start     (start),
    .data_in   (data_in),
    .len       (len),
    .det_y     (det_y),
    .det_w     (det_w),
    .det_rs    (det_rs),
    .busy      (busy),
    .done      (done),
    .hit_cnt   (hit_cnt),
    .first_hit (first_hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 1111 Moore detector: y is high while four or more 1s in a row
  // have been clocked in.
  int det_cnt = 0;
  always @(posedge clk) begin
    if (det_rs)     det_cnt <= 0;
    else if (det_w) det_cnt <= (det_cnt >= 4) ? 4 : det_cnt + 1;
    else            det_cnt <= 0;
  end
  assign det_y = (det_cnt >= 4);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: captures the serial stream for the scan at the queue head and
  // scores the result on done.
  logic [15:0] cap   = '0;
  int          stray = 0;
  int          mon_k;
  exp_t        e;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_k = cyc - q[0].c;
      if (mon_k >= 2 && mon_k <= q[0].len_eff + 1) cap[15-(mon_k-2)] = det_w;
      else if (det_w) stray++;
      if (mon_k == 1) check("clr_det_rs", {31'd0, det_rs}, 1);
    end
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 0);
      end else begin
        e = q.pop_front();
        check("hit_cnt",   {27'd0, hit_cnt},   e.hits);
        check("first_hit", {27'd0, first_hit}, e.first);
        check("latency",   cyc - e.c,          e.lat);
        check("det_w_seq", {16'd0, cap},       {16'd0, e.word});
        check("det_w_idle", stray,             0);
        cap   = '0;
        stray = 0;
      end
    end
  end

  task automatic run_scan(input logic [15:0] d, input logic [4:0] l, input int le,
                          input int hits, input int first, input int lat,
                          input logic [15:0] word);
    exp_t x;
    int   n;
    @(negedge clk);
    data_in = d;
    len     = l;
    start   = 1'b1;
    x.len_eff = le; x.hits = hits; x.first = first; x.lat = lat; x.word = word; x.c = cyc;
    q.push_back(x);
    @(negedge clk);
    start   = 1'b0;
    data_in = ~d;
    len     = 5'd2;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("scan_finished", {31'd0, busy}, 0);
    check("hold_hit_cnt",   {27'd0, hit_cnt},   hits);
    check("hold_first_hit", {27'd0, first_hit}, first);
  endtask

  initial begin
    int c0;
    rs = 1'b1; start = 1'b1; data_in = 16'hFFFF; len = 5'd16;
    repeat (2) @(negedge clk);
    check("rst_busy",      {31'd0, busy},      0);
    check("rst_done",      {31'd0, done},      0);
    check("rst_det_rs",    {31'd0, det_rs},    1);
    check("rst_hit_cnt",   {27'd0, hit_cnt},   0);
    check("rst_first_hit", {27'd0, first_hit}, 31);
    rs = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 0);
    check("post_rst_det_rs", {31'd0, det_rs}, 0);

    run_scan(16'hF000, 5'd16, 16, 1,  3,  19, 16'hF000);
    run_scan(16'hFFFF, 5'd0,  16, 13, 3,  19, 16'hFFFF);
    run_scan(16'hF7BC, 5'd16, 16, 3,  3,  19, 16'hF7BC);
    run_scan(16'hFFFF, 5'd3,  3,  0,  31, 6,  16'hE000);
    run_scan(16'h0F00, 5'd31, 16, 1,  7,  19, 16'h0F00);

    // Abort: a second start while busy is ignored, then reset mid-scan.
    @(negedge clk);
    c0 = cyc;
    data_in = 16'hFFFF; len = 5'd16; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc - c0 < 4) @(negedge clk);
    data_in = 16'h0000; len = 5'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc - c0 < 7) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 1);
    rs = 1'b1;
    @(negedge clk);
    check("abort_busy",      {31'd0, busy},      0);
    check("abort_done",      {31'd0, done},      0);
    check("abort_hit_cnt",   {27'd0, hit_cnt},   0);
    check("abort_first_hit", {27'd0, first_hit}, 31);
    check("abort_det_rs",    {31'd0, det_rs},    1);
    rs = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_stays_idle", {31'd0, busy}, 0);

    run_scan(16'hFFFF, 5'd16, 16, 13, 3, 19, 16'hFFFF);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
